// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the radix-2 restoring divide unit.
//   DIV_WIDTH    default operand / quotient / remainder width
//   DIV_TAG_W    default reservation-station tag width
//   DIV_ZERO_QUO quotient reported when the divisor is zero (all ones)
//   div_state_e  controller states
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_TAG_W = 4;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_i      partial remainder before the shift
//   bit_i      next dividend bit shifted into the remainder
//   divisor_i  divisor magnitude
//   rem_o      partial remainder after the trial subtraction
//   q_o        quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH-1:0] shifted_lo;

  assign shifted_lo = {rem_i[WIDTH-2:0], bit_i};

  // The shifted remainder is WIDTH+1 bits wide; the trial difference is
  // non-negative exactly when it is >= the divisor. When it is, the true
  // difference is below the divisor and therefore fits in WIDTH bits.
  assign q_o   = ({rem_i, bit_i} >= {1'b0, divisor_i});
  assign rem_o = q_o ? (shifted_lo - divisor_i) : shifted_lo;

endmodule

// File: rtl/div_unit_32.sv
// div_unit_32: multi-cycle integer divide unit, one quotient bit per cycle.
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             abort the in-flight operation, result discarded
//   in_valid/in_ready request handshake (dividend, divisor, signed, tag)
//   out_valid/out_ready result handshake toward the CDB arbiter
//   out_quotient, out_remainder, out_tag, out_div_by_zero  registered result
//
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | restoring iterations on operand magnitudes
//   DONE  | result held until out_ready
module div_unit_32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] out_quo_q, out_quo_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_dbz_q, out_dbz_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH-1:0] quo_fin, rem_fin;

  assign dvd_neg = in_signed & in_dividend[WIDTH-1];
  assign dvs_neg = in_signed & in_divisor[WIDTH-1];
  // -2^(WIDTH-1) maps onto itself, which is its correct unsigned magnitude.
  assign dvd_mag = dvd_neg ? -in_dividend : in_dividend;
  assign dvs_mag = dvs_neg ? -in_divisor  : in_divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign quo_shift = {quo_q[WIDTH-2:0], step_q};
  assign quo_fin   = q_neg_q ? -quo_shift : quo_shift;
  assign rem_fin   = r_neg_q ? -step_rem  : step_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    tag_d     = tag_q;
    out_quo_d = out_quo_q;
    out_rem_d = out_rem_q;
    out_tag_d = out_tag_q;
    out_dbz_d = out_dbz_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            tag_d   = in_tag;
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            if (in_divisor == '0) begin
              out_quo_d = WIDTH'(DIV_ZERO_QUO);
              out_rem_d = in_dividend;
              out_tag_d = in_tag;
              out_dbz_d = 1'b1;
              state_d   = DONE;
            end else begin
              rem_d   = '0;
              quo_d   = dvd_mag;
              dvs_d   = dvs_mag;
              cnt_d   = '0;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = step_rem;
          quo_d = quo_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            out_quo_d = quo_fin;
            out_rem_d = rem_fin;
            out_tag_d = tag_q;
            out_dbz_d = 1'b0;
            state_d   = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      tag_q     <= '0;
      out_quo_q <= '0;
      out_rem_q <= '0;
      out_tag_q <= '0;
      out_dbz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      tag_q     <= tag_d;
      out_quo_q <= out_quo_d;
      out_rem_q <= out_rem_d;
      out_tag_q <= out_tag_d;
      out_dbz_q <= out_dbz_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == DONE);
  assign out_quotient    = out_quo_q;
  assign out_remainder   = out_rem_q;
  assign out_tag         = out_tag_q;
  assign out_div_by_zero = out_dbz_q;

endmodule
